// File: rtl/wheel_speed_encoder.sv
// Wheel-sensor front end: sync + debounce the raw pulse, count rising edges per
// gate window, publish a saturated count and a hysteretic speed zone each window.
module wheel_speed_encoder #(
  parameter int GATE_CYCLES = 1000,
  parameter int DEBOUNCE    = 4,
  parameter int TH1         = 10,
  parameter int TH2         = 25,
  parameter int TH3         = 45,
  parameter int HYST        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       wheel_pulse,
  output logic [6:0] speed_count,
  output logic       speed_valid,
  output logic [1:0] speed_zone,
  output logic       speed_sat
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [6:0] T1_UP = 7'(TH1);
  localparam logic [6:0] T2_UP = 7'(TH2);
  localparam logic [6:0] T3_UP = 7'(TH3);
  localparam logic [6:0] T1_DN = 7'(TH1 - HYST);
  localparam logic [6:0] T2_DN = 7'(TH2 - HYST);
  localparam logic [6:0] T3_DN = 7'(TH3 - HYST);

  typedef enum logic [1:0] {Z0 = 2'd0, Z1 = 2'd1, Z2 = 2'd2, Z3 = 2'd3} zone_t;

  logic [1:0]    r_sync;
  logic          r_filt;
  logic          r_filt_d;
  logic [DW-1:0] r_db_cnt;
  logic [GW-1:0] r_gate;
  logic [6:0]    r_pulse;
  logic [6:0]    r_count;
  logic          r_sat;
  logic          r_valid;
  zone_t         r_zone;
  zone_t         w_zone_nxt;
  logic          w_edge;
  logic          w_close;
  logic [7:0]    w_sum;
  logic [6:0]    w_sum_sat;

  // Filtered level only moves after DEBOUNCE consecutive mismatching samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_filt   <= 1'b0;
      r_filt_d <= 1'b0;
      r_db_cnt <= '0;
    end else if (ena) begin
      r_sync   <= {r_sync[0], wheel_pulse};
      r_filt_d <= r_filt;
      if (r_sync[1] == r_filt) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_filt   <= r_sync[1];
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  assign w_edge    = r_filt & ~r_filt_d;
  assign w_close   = (r_gate == GATE_LAST);
  assign w_sum     = {1'b0, r_pulse} + {7'd0, w_edge};
  assign w_sum_sat = (w_sum >= 8'd127) ? 7'd127 : w_sum[6:0];

  // An edge on the close cycle is folded into the window being closed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gate  <= '0;
      r_pulse <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
      r_valid <= 1'b0;
    end else if (ena) begin
      r_valid <= w_close;
      if (w_close) begin
        r_gate  <= '0;
        r_pulse <= '0;
        r_count <= w_sum_sat;
        r_sat   <= (w_sum >= 8'd127);
      end else begin
        r_gate  <= r_gate + 1'b1;
        r_pulse <= w_sum_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)   r_zone <= Z0;
    else if (ena) r_zone <= w_zone_nxt;
  end

  always_comb begin
    w_zone_nxt = r_zone;
    if (w_close) begin
      case (r_zone)
        Z0: if (w_sum_sat >= T1_UP) w_zone_nxt = Z1;
        Z1: if (w_sum_sat >= T2_UP) w_zone_nxt = Z2;
            else if (w_sum_sat < T1_DN) w_zone_nxt = Z0;
        Z2: if (w_sum_sat >= T3_UP) w_zone_nxt = Z3;
            else if (w_sum_sat < T2_DN) w_zone_nxt = Z1;
        Z3: if (w_sum_sat < T3_DN) w_zone_nxt = Z2;
        default: w_zone_nxt = Z0;
      endcase
    end
  end

  always_comb begin
    speed_count = r_count;
    speed_zone  = r_zone;
    speed_sat   = r_sat;
    speed_valid = r_valid & ena;
  end

endmodule

// File: tb/tb_wheel_speed_encoder.sv
// Directed bench: two encoders (debounce 2 and debounce 1), 400-cycle windows,
// hand-computed counts/zones checked on each strobe.
module tb_wheel_speed_encoder;

  logic       clk = 1'b0;
  logic       rst_n_a = 1'b0, ena_a = 1'b1, wheel_a = 1'b0;
  logic       rst_n_b = 1'b0, ena_b = 1'b1, wheel_b = 1'b0;
  logic [6:0] count_a, count_b;
  logic [1:0] zone_a, zone_b;
  logic       valid_a, valid_b, sat_a, sat_b;

  int cyc = 0;
  int nchk = 0, npass = 0, nfail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wheel_speed_encoder #(.GATE_CYCLES(400), .DEBOUNCE(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .ena(ena_a), .wheel_pulse(wheel_a),
    .speed_count(count_a), .speed_valid(valid_a), .speed_zone(zone_a), .speed_sat(sat_a));

  wheel_speed_encoder #(.GATE_CYCLES(400), .DEBOUNCE(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .ena(ena_b), .wheel_pulse(wheel_b),
    .speed_count(count_b), .speed_valid(valid_b), .speed_zone(zone_b), .speed_sat(sat_b));

  task automatic check(input string tag, input int obs, input int exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulses(input bit sel, input int n, input int hi, input int lo);
    for (int i = 0; i < n; i++) begin
      if (sel) wheel_b = 1'b1; else wheel_a = 1'b1;
      repeat (hi) @(negedge clk);
      if (sel) wheel_b = 1'b0; else wheel_a = 1'b0;
      repeat (lo) @(negedge clk);
    end
  endtask

  task automatic wait_strobe(input bit sel, input string tag);
    int found;
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if ((sel ? valid_b : valid_a) === 1'b1) begin
        found = 1;
        break;
      end
    end
    check({tag, "_strobe_seen"}, found, 1);
  endtask

  initial begin
    int last;
    int x;
    repeat (3) @(negedge clk);
    check("rst_count", count_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_zone", zone_a, 0);
    check("rst_sat", sat_a, 0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    last = cyc;

    // 1-cycle glitches never survive a 2-sample debounce
    for (int i = 0; i < 30; i++) pulses(1'b0, 1, 1, 9);
    wait_strobe(1'b0, "glitch");
    check("glitch_period", cyc - last, 400);
    check("glitch_count", count_a, 0);
    check("glitch_zone", zone_a, 0);
    check("glitch_sat", sat_a, 0);
    last = cyc;

    pulses(1'b0, 12, 3, 3);
    wait_strobe(1'b0, "basic");
    check("basic_period", cyc - last, 400);
    check("basic_count", count_a, 12);
    check("basic_zone", zone_a, 1);
    last = cyc;
    @(negedge clk);
    check("basic_valid_1cyc", valid_a, 0);
    check("basic_count_held", count_a, 12);

    pulses(1'b0, 50, 3, 3);
    wait_strobe(1'b0, "step1");
    check("step1_count", count_a, 50);
    check("step1_zone", zone_a, 2);
    check("step1_period", cyc - last, 400);
    last = cyc;
    pulses(1'b0, 50, 3, 3);
    wait_strobe(1'b0, "step2");
    check("step2_zone", zone_a, 3);

    pulses(1'b0, 23, 3, 3);
    wait_strobe(1'b0, "down3");
    check("down3_count", count_a, 23);
    check("down3_zone", zone_a, 2);
    pulses(1'b0, 23, 3, 3);
    wait_strobe(1'b0, "hyst_hold");
    check("hyst_hold_zone", zone_a, 2);
    pulses(1'b0, 21, 3, 3);
    wait_strobe(1'b0, "hyst_drop");
    check("hyst_drop_count", count_a, 21);
    check("hyst_drop_zone", zone_a, 1);
    last = cyc;

    // freeze 50 cycles mid-window: close slides out by exactly 50
    pulses(1'b0, 10, 3, 3);
    while (cyc < last + 100) @(negedge clk);
    ena_a = 1'b0;
    repeat (50) @(negedge clk);
    check("ena_valid_low", valid_a, 0);
    check("ena_count_held", count_a, 21);
    ena_a = 1'b1;
    wait_strobe(1'b0, "ena");
    check("ena_period", cyc - last, 450);
    check("ena_count", count_a, 10);
    check("ena_zone", zone_a, 1);

    pulses(1'b0, 5, 3, 3);
    rst_n_a = 1'b0;
    @(negedge clk);
    check("mid_rst_count", count_a, 0);
    check("mid_rst_zone", zone_a, 0);
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_sat", sat_a, 0);
    rst_n_a = 1'b1;
    last = cyc;
    wait_strobe(1'b0, "post_rst");
    check("post_rst_period", cyc - last, 400);
    check("post_rst_count", count_a, 0);

    // debounce-1 instance: saturation and close-cycle edge
    wait_strobe(1'b1, "b_align");
    pulses(1'b1, 150, 1, 1);
    wait_strobe(1'b1, "sat");
    check("sat_count", count_b, 127);
    check("sat_flag", sat_b, 1);
    check("sat_zone", zone_b, 1);
    x = cyc;
    pulses(1'b1, 4, 1, 1);
    while (cyc < x + 396) @(negedge clk);
    wheel_b = 1'b1;
    @(negedge clk);
    wheel_b = 1'b0;
    wait_strobe(1'b1, "close_edge");
    check("close_edge_period", cyc - x, 400);
    check("close_edge_count", count_b, 5);
    check("close_edge_sat", sat_b, 0);
    check("close_edge_zone", zone_b, 0);
    wait_strobe(1'b1, "after_close");
    check("after_close_count", count_b, 0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule

// File: doc/wheel_speed_encoder.md
Name: wheel_speed_encoder

Overview:
Front-end producer for the automatic-gearbox FSM's input bus. It conditions the raw wheel-sensor pulse and counts pulses over a fixed gate window. Each window it publishes a saturated speed count plus a hysteretic speed zone (Z0..Z3). These drive the gearbox controller's speed inputs on ui_in. Single clock domain, Tiny-Tapeout-style ena gating.

Parameters:
GATE_CYCLES, 1000, clock cycles per measurement window (>= 2)
DEBOUNCE, 4, consecutive stable synced samples needed to change the filtered level (>= 1)
TH1, 10, up-threshold Z0->Z1 (counts per window)
TH2, 25, up-threshold Z1->Z2
TH3, 45, up-threshold Z2->Z3
HYST, 3, down-hysteresis; requires TH1 > HYST and TH1 < TH2 < TH3 <= 127

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset, sampled on rising clk
ena  input  1  enable; when 0 all internal state holds
wheel_pulse  input  1  raw asynchronous wheel sensor, may glitch
speed_count  output  7  pulses counted in last closed window, saturated at 127
speed_valid  output  1  one-cycle strobe; speed_count and speed_zone were updated this cycle
speed_zone  output  2  current zone 0..3 (Z0..Z3)
speed_sat  output  1  1 if last closed window saturated (true count >= 127)

Behaviour:
- Reset (rst_n=0 at a rising edge) clears everything: speed_count=0, speed_valid=0, speed_zone=Z0, speed_sat=0, sync flops=0, filtered level=0, debounce counter=0, gate counter=0, pulse counter=0. Reset mid-window discards the partial window; no strobe is produced.
- ena=0 freezes all registers, including the synchronizer. speed_valid is forced 0 while ena=0.
- Synchronizer: 2-flop chain on wheel_pulse.
- Debounce: stable counter increments while sync_out != filtered, and clears when they are equal. When the counter reaches DEBOUNCE, filtered takes sync_out and the counter clears.
  - Pulses shorter than DEBOUNCE cycles are rejected.
  - Latency from the raw edge to the filtered edge is 2+DEBOUNCE cycles.
- Edge detect: a rising edge of filtered produces a one-cycle edge event.
- Gate counter runs 0..GATE_CYCLES-1 and wraps.
  - On the cycle where it equals GATE_CYCLES-1 (the close cycle), at the next edge:
    - speed_count <= min(pulse_cnt + edge, 127)
    - speed_sat <= (pulse_cnt + edge >= 127)
    - pulse_cnt <= 0
    - speed_valid <= 1
    - zone update as below
  - An edge coinciding with the close cycle counts toward the closing window, not the next one.
  - On every other cycle: pulse_cnt <= pulse_cnt + edge, saturating at 127 internally; speed_valid <= 0.
- Zone FSM, evaluated only on the close cycle, using the new count C. It moves at most one zone per window.
  - Z0: C >= TH1 -> Z1, else stay.
  - Z1: C >= TH2 -> Z2; C < TH1-HYST -> Z0; else stay.
  - Z2: C >= TH3 -> Z3; C < TH2-HYST -> Z1; else stay.
  - Z3: C < TH3-HYST -> Z2; else stay.
- All outputs are registered; no combinational path from wheel_pulse to any output.
- speed_count, speed_zone and speed_sat change only when speed_valid pulses.

Test Plan:
- Glitch rejection: GATE_CYCLES=400, DEBOUNCE=2. Send 30 one-cycle high glitches spaced 10 cycles apart -> strobe shows speed_count=0, speed_zone=Z0, speed_sat=0.
- Basic count: same parameters, 12 clean pulses (3 high / 3 low) inside one window -> speed_count=12, speed_zone Z0->Z1, speed_valid high exactly 1 cycle every 400 cycles.
- One-step-per-window: from Z1, send 50 pulses/window for two windows.
  - First strobe: speed_count=50, zone=Z2, not Z3.
  - Second strobe: zone=Z3.
- Hysteresis: from Z2, send 23 pulses -> stays Z2 (23 >= 22). Then send 21 pulses -> Z1.
- Saturation and boundary: DEBOUNCE=1, 1 high / 1 low pulses for the full window -> speed_count=127, speed_sat=1. A single edge landing exactly on the close cycle is counted in that window: 5 pulses with the last on the close cycle -> speed_count=5.
- ena/reset: drop ena for 50 cycles mid-window -> strobe delayed by 50 cycles, count unchanged. Assert rst_n=0 mid-window -> outputs 0/Z0 next cycle, and the first strobe comes GATE_CYCLES cycles after release.
